// File: rtl/alu_uart_pkg.sv
// rtl/alu_uart_pkg.sv - shared state encodings and ALU opcode constants
package alu_uart_pkg;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_LATCH   = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        LATCH   = ST_LATCH,
        SEND    = ST_SEND,
        WAIT_TX = ST_WAIT_TX
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// rtl/alu_uart_ctrl_if.sv - UART/ALU side signals of the sequencing controller
//   master: controller view (UART/ALU inputs, operand/tx/status outputs)
//   slave : environment view (drives rx/tx strobes and ALU result)
interface alu_uart_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_opcode;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;

    modport master (
        input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        output o_data_a, o_data_b, o_opcode, o_tx_start, o_tx_data,
               o_busy, o_timeout, o_overrun
    );

    modport slave (
        output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        input  o_data_a, o_data_b, o_opcode, o_tx_start, o_tx_data,
               o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/alu_uart_ctrl_frame_timer.sv
// rtl/alu_uart_ctrl_frame_timer.sv - inter-byte timer, flags count == TIMEOUT-1
//   i_clk, i_reset (sync, active-low); clear, enable in; terminal out
module frame_timer #(
    parameter int TIMEOUT = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int         W  = $clog2(TIMEOUT);
    localparam logic [W-1:0] TC = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    assign terminal = (count == TC);

    // Holds at terminal count; the controller leaves the timed states there.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - collects A/B/opcode bytes, feeds ALU, launches result tx
//   i_clk, i_reset (sync, active-low); bus: alu_uart_ctrl_if.master
module alu_uart_ctrl
    import alu_uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 100000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    alu_uart_ctrl_if.master bus
);
    state_t state, state_next;

    logic               accept;
    logic               timeout_next;
    logic               overrun_next;
    logic               tc;
    logic               timer_clear;
    logic               timer_en;

    logic [NB_DATA-1:0] data_a, data_b, tx_data;
    logic [NB_OP-1:0]   opcode;
    logic               tx_start, busy, timeout, overrun;

    // Counter restarts on each accepted byte and is held cleared while idle,
    // which also covers re-entry to WAIT_A.
    assign timer_en    = (state == WAIT_B) || (state == WAIT_OP);
    assign timer_clear = accept || (state == WAIT_A);

    frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .terminal(tc)
    );

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        timeout_next = 1'b0;
        overrun_next = 1'b0;
        case (state)
            WAIT_A: begin
                if (bus.i_rx_done) begin
                    accept     = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte in the terminal-count cycle wins over the timeout.
                if (bus.i_rx_done) begin
                    accept     = 1'b1;
                    state_next = WAIT_OP;
                end else if (tc) begin
                    timeout_next = 1'b1;
                    state_next   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    accept     = 1'b1;
                    state_next = LATCH;
                end else if (tc) begin
                    timeout_next = 1'b1;
                    state_next   = WAIT_A;
                end
            end
            LATCH: state_next = SEND;
            SEND: begin
                overrun_next = bus.i_rx_done;
                state_next   = WAIT_TX;
            end
            WAIT_TX: begin
                overrun_next = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= WAIT_A;
            data_a   <= '0;
            data_b   <= '0;
            opcode   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            tx_start <= (state == LATCH);
            busy     <= (state_next != WAIT_A);
            timeout  <= timeout_next;
            overrun  <= overrun_next;
            if (accept && state == WAIT_A)  data_a <= bus.i_rx_data;
            if (accept && state == WAIT_B)  data_b <= bus.i_rx_data;
            if (accept && state == WAIT_OP) opcode <= bus.i_rx_data[NB_OP-1:0];
            if (state == LATCH)             tx_data <= bus.i_alu_result;
        end
    end

    assign bus.o_data_a   = data_a;
    assign bus.o_data_b   = data_b;
    assign bus.o_opcode   = opcode;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_start = tx_start;
    assign bus.o_busy     = busy;
    assign bus.o_timeout  = timeout;
    assign bus.o_overrun  = overrun;
endmodule
